pdm_level_sequencer: RTL and testbench

//  Upstream feeder for the tile's 5-bit PDM modulator. Stores a short table of PDM levels,

---
 rtl/pdm_seq_pkg.sv | 16 +
 rtl/pdm_seq_table.sv | 26 ++
 rtl/pdm_level_sequencer.sv | 155 +++++++++++++++
 tb/tb_pdm_level_sequencer.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pdm_seq_pkg.sv
// Shared types and default sizing for the PDM level sequencer.
package pdm_seq_pkg;

  // Playback sequencer states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_DONE = 2'd2
  } pdm_seq_state_e;

  // Default table depth, level width and strobe cadence
  localparam int PDM_SEQ_DEPTH   = 8;
  localparam int PDM_SEQ_LEVEL_W = 5;
  localparam int PDM_SEQ_PERIOD  = 64;

endpackage

// File: rtl/pdm_seq_table.sv
// DEPTH x LEVEL_W level table: synchronous write, asynchronous read.
// Storage is deliberately not reset; the table is only meaningful after loads.
module pdm_seq_table #(
  parameter int DEPTH   = 8,
  parameter int LEVEL_W = 5
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [LEVEL_W-1:0]       wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [LEVEL_W-1:0]       rdata
);

  logic [LEVEL_W-1:0] mem_q [DEPTH];

  // Write one entry per accepted load
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/pdm_level_sequencer.sv
// PDM level sequencer: loads a short table of levels, then plays it back to
// the modulator as one wr_en strobe plus a new level every PERIOD clocks.
// Handshake: a load transfers on a clock edge where load_valid && load_ready;
// load_ready is high only in IDLE and does not depend on load_valid.
// Build option PDM_SEQ_LOOP_EN: playback wraps to entry 0 forever, only stop
// leaves PLAY and done never pulses. Undefined: single pass ending in DONE.
module pdm_level_sequencer
  import pdm_seq_pkg::*;
#(
  parameter int DEPTH   = PDM_SEQ_DEPTH,
  parameter int LEVEL_W = PDM_SEQ_LEVEL_W,
  parameter int PERIOD  = PDM_SEQ_PERIOD
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               tbl_clr,
  input  logic               load_valid,
  input  logic [LEVEL_W-1:0] load_data,
  output logic               load_ready,
  input  logic               start,
  input  logic               stop,
  output logic               wr_en,
  output logic [LEVEL_W-1:0] pdm_level,
  output logic               busy,
  output logic               done
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(PERIOD);
  localparam logic [TW-1:0] TICK_LAST  = TW'(PERIOD - 1);
  localparam logic [CW-1:0] COUNT_FULL = CW'(DEPTH);

  pdm_seq_state_e     state_q, state_d;
  logic [AW-1:0]      wptr_q, wptr_d;
  logic [CW-1:0]      count_q, count_d;
  logic [CW-1:0]      rptr_q, rptr_d;
  logic [TW-1:0]      tick_q, tick_d;
  logic               wr_en_q, wr_en_d;
  logic [LEVEL_W-1:0] level_q, level_d;

  logic               tbl_we;
  logic [AW-1:0]      rd_addr;
  logic [LEVEL_W-1:0] rd_data;

  pdm_seq_table #(
    .DEPTH  (DEPTH),
    .LEVEL_W(LEVEL_W)
  ) u_table (
    .clk  (clk),
    .we   (tbl_we),
    .waddr(wptr_q),
    .wdata(load_data),
    .raddr(rd_addr),
    .rdata(rd_data)
  );

  // Next-state, counter and output-register logic
  always_comb begin
    state_d = state_q;
    wptr_d  = wptr_q;
    count_d = count_q;
    rptr_d  = rptr_q;
    tick_d  = tick_q;
    wr_en_d = 1'b0;
    level_d = level_q;
    tbl_we  = 1'b0;
    // Outside PLAY, and on the wrap past the last entry, the read port shows entry 0
    rd_addr = (state_q == ST_PLAY && rptr_q != count_q) ? rptr_q[AW-1:0] : '0;

    case (state_q)
      ST_IDLE: begin
        if (tbl_clr) begin
          wptr_d  = '0;
          count_d = '0;
        end else if (load_valid) begin
          tbl_we = 1'b1;
          wptr_d = wptr_q + AW'(1);
          if (count_q != COUNT_FULL) begin
            count_d = count_q + CW'(1);
          end
        end
        // Start sees the count after this cycle's load/clear
        if (start && count_d != '0) begin
          state_d = ST_PLAY;
          wr_en_d = 1'b1;
          tick_d  = '0;
          rptr_d  = CW'(1);
          // Entry 0 written this same cycle is not in the table yet: bypass it
          level_d = (tbl_we && wptr_q == '0) ? load_data : rd_data;
        end
      end

      ST_PLAY: begin
        if (stop) begin
          state_d = ST_IDLE;
          tick_d  = '0;
        end else if (tick_q == TICK_LAST) begin
          tick_d = '0;
          if (rptr_q != count_q) begin
            wr_en_d = 1'b1;
            level_d = rd_data;
            rptr_d  = rptr_q + CW'(1);
          end else begin
`ifdef PDM_SEQ_LOOP_EN
            wr_en_d = 1'b1;
            level_d = rd_data;
            rptr_d  = CW'(1);
`else
            state_d = ST_DONE;
`endif
          end
        end else begin
          tick_d = tick_q + TW'(1);
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and counter registers, asynchronously cleared
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      wptr_q  <= '0;
      count_q <= '0;
      rptr_q  <= '0;
      tick_q  <= '0;
      wr_en_q <= 1'b0;
      level_q <= '0;
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      count_q <= count_d;
      rptr_q  <= rptr_d;
      tick_q  <= tick_d;
      wr_en_q <= wr_en_d;
      level_q <= level_d;
    end
  end

  assign wr_en      = wr_en_q;
  assign pdm_level  = level_q;
  assign busy       = (state_q == ST_PLAY);
  assign done       = (state_q == ST_DONE);
  assign load_ready = (state_q == ST_IDLE);

endmodule

// File: tb/tb_pdm_level_sequencer.sv
// Directed bench for pdm_level_sequencer (DEPTH 8, LEVEL_W 5, PERIOD 64).
// Follows PDM_SEQ_LOOP_EN the same way the design does.
module tb_pdm_level_sequencer;

  localparam int LW = 5;

  // Clock and reset
  logic          clk = 1'b0;
  logic          reset_n;
  logic          tbl_clr;
  logic          load_valid;
  logic [LW-1:0] load_data;
  logic          load_ready;
  logic          start;
  logic          stop;
  logic          wr_en;
  logic [LW-1:0] pdm_level;
  logic          busy;
  logic          done;

  always #5 clk = ~clk;

  pdm_level_sequencer dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .tbl_clr   (tbl_clr),
    .load_valid(load_valid),
    .load_data (load_data),
    .load_ready(load_ready),
    .start     (start),
    .stop      (stop),
    .wr_en     (wr_en),
    .pdm_level (pdm_level),
    .busy      (busy),
    .done      (done)
  );

  int n_cmp = 0;
  int n_err = 0;
  logic [LW-1:0] exp_q[$];

  // Scoreboard comparison
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Driver tasks: each starts and ends just after a falling edge
  task automatic load(input logic [LW-1:0] v);
    load_valid = 1'b1;
    load_data  = v;
    @(negedge clk);
    load_valid = 1'b0;
  endtask

  task automatic clr();
    tbl_clr = 1'b1;
    @(negedge clk);
    tbl_clr = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
  endtask

  // Advance until a strobe or done is visible, bounded
  task automatic run_until(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(wr_en || done) && n < 300);
  endtask

  task automatic idle_watch(input string tag, input int cyc);
    int seen = 0;
    repeat (cyc) begin
      @(negedge clk);
      if (wr_en || busy || done) seen++;
    end
    chk(tag, seen, 0);
  endtask

  // End of a playback: done pulse, or in loop builds a replay of entry 0 then stop
  task automatic expect_end(input string tag, input logic [LW-1:0] first, input logic [LW-1:0] last);
    int n;
    run_until(n);
    chk({tag, " end_gap"}, n, 64);
`ifdef PDM_SEQ_LOOP_EN
    chk({tag, " wrap_wr_en"}, wr_en, 1);
    chk({tag, " wrap_level"}, pdm_level, first);
    chk({tag, " wrap_no_done"}, done, 0);
    pulse_stop();
    chk({tag, " stop_busy"}, busy, 0);
    chk({tag, " stop_wr_en"}, wr_en, 0);
    chk({tag, " stop_level"}, pdm_level, first);
`else
    chk({tag, " done"}, done, 1);
    chk({tag, " done_wr_en"}, wr_en, 0);
    chk({tag, " done_level"}, pdm_level, last);
    chk({tag, " done_busy"}, busy, 0);
    @(negedge clk);
    chk({tag, " done_pulse_len"}, done, 0);
    chk({tag, " idle_ready"}, load_ready, 1);
`endif
  endtask

  // Start playback and check every strobe against exp_q
  task automatic play_and_check(input string tag);
    int n;
    logic [LW-1:0] e, first, last;
    pulse_start();
    chk({tag, " first_wr_en"}, wr_en, 1);
    chk({tag, " busy"}, busy, 1);
    chk({tag, " ready_low"}, load_ready, 0);
    e = exp_q.pop_front();
    chk({tag, " first_level"}, pdm_level, e);
    first = e;
    last  = e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      run_until(n);
      chk({tag, " gap"}, n, 64);
      chk({tag, " wr_en"}, wr_en, 1);
      chk({tag, " level"}, pdm_level, e);
      last = e;
    end
    expect_end(tag, first, last);
  endtask

  initial begin
    int n;
    reset_n    = 1'b0;
    tbl_clr    = 1'b0;
    load_valid = 1'b0;
    load_data  = '0;
    start      = 1'b0;
    stop       = 1'b0;
    repeat (4) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Reset values
    chk("rst wr_en", wr_en, 0);
    chk("rst level", pdm_level, 0);
    chk("rst load_ready", load_ready, 1);
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);

    // Start with an empty table is ignored
    pulse_start();
    idle_watch("empty_start", 70);

    // Four-entry playback
    load(5'h08);
    load(5'h1a);
    load(5'h0f);
    load(5'h04);
    chk("load ready", load_ready, 1);
    exp_q = '{5'h08, 5'h1a, 5'h0f, 5'h04};
    play_and_check("play4");

    // Start right after clear, and clear winning over a same-cycle load
    clr();
    pulse_start();
    idle_watch("clr_start", 70);
    tbl_clr    = 1'b1;
    load_valid = 1'b1;
    load_data  = 5'h1e;
    @(negedge clk);
    tbl_clr    = 1'b0;
    load_valid = 1'b0;
    pulse_start();
    idle_watch("clr_beats_load", 70);

    // Nine loads: entry 0 overwritten, count saturates at 8
    clr();
    for (int i = 1; i <= 9; i++) load(LW'(i));
    exp_q = '{5'd9, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8};
    play_and_check("wrap9");

    // Stop 10 clocks after the second strobe
    pulse_start();
    chk("stop first_level", pdm_level, 5'd9);
    run_until(n);
    chk("stop gap2", n, 64);
    chk("stop level2", pdm_level, 5'd2);
    repeat (10) @(negedge clk);
    pulse_stop();
    chk("stop busy", busy, 0);
    chk("stop ready", load_ready, 1);
    chk("stop level_hold", pdm_level, 5'd2);
    idle_watch("stop quiet", 150);
    // Next load lands at wptr=1 (count already full)
    load(5'h15);
    exp_q = '{5'd9, 5'h15, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8};
    play_and_check("append");

    // Same-cycle load and start into an empty table
    clr();
    load_valid = 1'b1;
    load_data  = 5'h11;
    start      = 1'b1;
    @(negedge clk);
    load_valid = 1'b0;
    start      = 1'b0;
    chk("ldstart wr_en", wr_en, 1);
    chk("ldstart level", pdm_level, 5'h11);
    chk("ldstart busy", busy, 1);
    expect_end("ldstart", 5'h11, 5'h11);

    // Stop in the same cycle as a strobe suppresses it
    load(5'h0a);
    pulse_start();
    chk("stopstrobe first", pdm_level, 5'h11);
    repeat (63) @(negedge clk);
    pulse_stop();
    chk("stopstrobe wr_en", wr_en, 0);
    chk("stopstrobe busy", busy, 0);
    chk("stopstrobe level", pdm_level, 5'h11);

    // Asynchronous reset in the middle of a strobe
    pulse_start();
    chk("arst pre wr_en", wr_en, 1);
    #1 reset_n = 1'b0;
    #1;
    chk("arst wr_en", wr_en, 0);
    chk("arst level", pdm_level, 0);
    chk("arst busy", busy, 0);
    chk("arst ready", load_ready, 1);
    @(negedge clk);
    reset_n = 1'b1;
    pulse_start();
    idle_watch("arst count_cleared", 70);

`ifdef PDM_SEQ_LOOP_EN
    // Two-entry table loops until stopped
    load(5'h03);
    load(5'h1f);
    exp_q = '{5'h03, 5'h1f, 5'h03, 5'h1f, 5'h03, 5'h1f};
    play_and_check("loop2");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
